uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter for the scan-chain UART link. Accepts parallel words over a valid/ready handshake and sends each one as an asynchronous frame on `tx`: start bit, data LSB first, then stop bit(s). Bit timing is derived from the same 16x-baud reference clock that the receive-side clock recovery uses, so it returns scan data (TDO) to the host at the host's baud rate.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `CLKS_PER_BIT`, default 16: clocks per serial bit; power of two, minimum 4.
- `clk` input 1: 16x baud reference clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `tx_data` input DATA_BITS: word to send; sampled only on handshake.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: block can accept a word this cycle.
- `tx` output 1: serial line, registered; idles high.
- `busy` output 1: a frame is in progress.

## Operation
- **Reset values** (with `rst` high, and in the cycle after): `tx`=1, `busy`=0, `tx_ready`=0. All counters clear, state is IDLE, and the shift register clears.
- **States:** IDLE, START, DATA, STOP.
- **Handshake:** a word is accepted on a rising edge where `tx_valid`=1 and `tx_ready`=1.
  - On acceptance, `tx_data` is latched into the shift register.
  - Later changes to `tx_data` or `tx_valid` have no effect on the frame in progress.
- **`tx_ready`:** combinational. It is 1 when `rst`=0 and either:
  - state is IDLE, or
  - state is STOP, the bit counter is on its last stop bit, and the clock counter is CLKS_PER_BIT-1.
- **Bit timer:** `clk_cnt` is log2(CLKS_PER_BIT) bits. It counts 0..CLKS_PER_BIT-1 and wraps. It resets to 0 on every state entry.
- **Bit counter:** `bit_cnt` is 4 bits. It counts data bits 0..DATA_BITS-1 in DATA and stop bits 0..STOP_BITS-1 in STOP.
- **Transitions:**
  - IDLE → START on acceptance.
  - START → DATA when `clk_cnt` wraps.
  - DATA → STOP when `clk_cnt` wraps on bit DATA_BITS-1. Otherwise `bit_cnt` increments and the shift register shifts right by one.
  - STOP → IDLE when `clk_cnt` wraps on the last stop bit and there is no acceptance.
  - STOP → START when `clk_cnt` wraps on the last stop bit and a word is accepted on that same edge.
- **`tx` value:** registered, driven from the next state.
  - 0 in START.
  - Shift register bit 0 in DATA.
  - 1 in STOP and IDLE.
- **`busy`:** registered. It is 1 in START, DATA and STOP, and 0 in IDLE.
- **Reset mid-frame:** the frame is abandoned with no completion. `tx` returns high on the next cycle, and the word is discarded.
- **`tx_valid` during reset:** ignored; no acceptance occurs.

## Timing
- **Latency:** if acceptance happens on the edge ending cycle k, the start bit occupies cycles k+1 .. k+CLKS_PER_BIT.
- **Data bits:** data bit i occupies cycles k+1+CLKS_PER_BIT·(i+1) onward, for CLKS_PER_BIT cycles.
- **Frame length:** F = CLKS_PER_BIT·(1+DATA_BITS+STOP_BITS) cycles, occupying cycles k+1 .. k+F. For 8N1 at 16x, F = 160.
- **Back-to-back:** with `tx_valid` held, the next acceptance is on the edge ending cycle k+F. The next start bit begins at k+F+1, so there are no extra idle cycles and the frame period is exactly F.
- **From IDLE:** `tx_ready` is 1 immediately; minimum response is 1 cycle from acceptance to the `tx` falling edge.
- **Glitch-free `tx`:** `tx` changes only at bit boundaries, is stable for exactly CLKS_PER_BIT cycles per bit, and never glitches within a bit.
- **Receiver margin:** a receiver sampling at mid-bit (`clk_cnt`=CLKS_PER_BIT/2) sees a stable value.

## Test plan
- **Reset with pending data:** hold `rst`=1 for 3 cycles with `tx_valid`=1 and `tx_data`=0x3C → `tx`=1, `tx_ready`=0, `busy`=0 throughout; no start bit for 200 cycles after `rst` falls if `tx_valid`=0.
- **Single 8N1 frame:** accept 0xA5 → `tx` low for 16 cycles, then 1,0,1,0,0,1,0,1 for 16 cycles each, then high for 16 cycles. `busy`=1 for exactly 160 cycles; `tx_ready` is 1 only in the final stop cycle and then in IDLE.
- **Back-to-back frames:** present 0x00 then 0xFF with `tx_valid` held → second start bit begins the cycle after the 16th stop cycle; start-to-start spacing is 160 cycles; `busy` never drops.
- **Data stability:** accept 0x81, then change `tx_data` to 0x7E at cycle 40 → the transmitted bits are still 0x81.
- **Reset mid-frame:** assert `rst` at cycle 50 of a frame → `tx`=1 and `busy`=0 from the next cycle. After release, accepting 0x5A produces a clean full frame.
- **Alternate parameters:** DATA_BITS=7, STOP_BITS=2, accept 0x55 → frame is 160 cycles (16·10) with bits 1,0,1,0,1,0,1 and two high stop bits. A loopback receiver sampling at mid-bit recovers 0x55.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: asynchronous serial transmitter, start bit, DATA_BITS data
// bits LSB first, STOP_BITS stop bits, CLKS_PER_BIT clocks per bit.
// Ports: clk, rst (sync, active high), tx_data/tx_valid/tx_ready
// (valid/ready word input), tx (registered serial line, idles high),
// busy (registered, high while a frame is in progress).
module uart_tx #(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   bit_wrap;
    logic                   accept;

    always_comb begin
        bit_wrap  = (clk_cnt_q == CLK_LAST);
        // Ready in IDLE, or on the very last cycle of the final stop bit
        // so back-to-back frames need no idle gap.
        tx_ready  = !rst && ((state_q == IDLE) ||
                    ((state_q == STOP) && (bit_cnt_q == STOP_LAST) && bit_wrap));
        accept    = tx_valid && tx_ready;

        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CW'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;

        unique case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (accept) begin
                    state_d = START;
                    shift_d = tx_data;
                end
            end
            START: begin
                if (bit_wrap) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_wrap) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            STOP: begin
                if (bit_wrap) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        if (accept) begin
                            state_d = START;
                            shift_d = tx_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
            end
        endcase

        // tx follows the next state so the line changes on the same edge
        // as the state register.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx in 8N1 and 7-data/2-stop forms.
// A frame-level queue model is checked every cycle, plus literal checks.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d8 = 8'h3C;
    logic       v8 = 1'b1;
    logic [6:0] d7 = 7'h3C;
    logic       v7 = 1'b1;
    logic       tx8, rdy8, busy8;
    logic       tx7, rdy7, busy7;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx dut8 (
        .clk(clk), .rst(rst), .tx_data(d8), .tx_valid(v8),
        .tx_ready(rdy8), .tx(tx8), .busy(busy8)
    );

    uart_tx #(.DATA_BITS(7), .STOP_BITS(2), .CLKS_PER_BIT(16)) dut7 (
        .clk(clk), .rst(rst), .tx_data(d7), .tx_valid(v7),
        .tx_ready(rdy7), .tx(tx7), .busy(busy7)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: each queue holds the expected tx level for every remaining
    // cycle of the frame in flight; empty means idle.
    bit q8[$];
    bit q7[$];

    function automatic void push_frame(ref bit q[$], input int data,
                                       input int nd, input int ns);
        for (int c = 0; c < 16; c++) q.push_back(1'b0);
        for (int i = 0; i < nd; i++)
            for (int c = 0; c < 16; c++) q.push_back(bit'((data >> i) & 1));
        for (int c = 0; c < 16 * ns; c++) q.push_back(1'b1);
    endfunction

    always @(posedge clk) begin
        bit r8, r7;
        r8 = (q8.size() <= 1);
        r7 = (q7.size() <= 1);
        if (rst) begin
            q8.delete();
            q7.delete();
        end else begin
            if (q8.size() > 0) void'(q8.pop_front());
            if (q7.size() > 0) void'(q7.pop_front());
            if (v8 && r8) push_frame(q8, int'(d8), 8, 1);
            if (v7 && r7) push_frame(q7, int'(d7), 7, 2);
        end
        chk_en <= 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m8_tx", int'(tx8), q8.size() > 0 ? int'(q8[0]) : 1);
            chk("m8_busy", int'(busy8), int'(q8.size() > 0));
            chk("m8_rdy", int'(rdy8), int'(!rst && q8.size() <= 1));
            chk("m7_tx", int'(tx7), q7.size() > 0 ? int'(q7[0]) : 1);
            chk("m7_busy", int'(busy7), int'(q7.size() > 0));
            chk("m7_rdy", int'(rdy7), int'(!rst && q7.size() <= 1));
        end
    end

    bit ct8[700], cb8[700], cr8[700];
    bit ct7[700], cb7[700];

    // Record n cycles starting at the cycle after an acceptance edge.
    task automatic capture(input int n, input int drop8, input int drop7,
                           input int chg_at, input logic [7:0] chg_val);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            ct8[j] = tx8; cb8[j] = busy8; cr8[j] = rdy8;
            ct7[j] = tx7; cb7[j] = busy7;
            if (j == drop8) v8 = 1'b0;
            if (j == drop7) v7 = 1'b0;
            if (j == chg_at) d8 = chg_val;
        end
    endtask

    // Mid-bit loopback receiver over the captured line.
    function automatic int rx8(input int base, input int nd);
        int w = 0;
        for (int i = 0; i < nd; i++)
            w |= int'(ct8[base + 16 * (i + 1) + 8]) << i;
        return w;
    endfunction

    function automatic int rx7(input int base, input int nd);
        int w = 0;
        for (int i = 0; i < nd; i++)
            w |= int'(ct7[base + 16 * (i + 1) + 8]) << i;
        return w;
    endfunction

    function automatic int count8b(input int lo, input int hi);
        int c = 0;
        for (int j = lo; j < hi; j++) c += int'(cb8[j]);
        return c;
    endfunction

    task automatic go8(input logic [7:0] d);
        @(negedge clk);
        d8 = d;
        v8 = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        int lows, seq;
        // Reset held 3 cycles with pending data.
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", int'(tx8), 1);
            chk("rst_busy", int'(busy8), 0);
            chk("rst_rdy", int'(rdy8), 0);
        end
        rst = 1'b0;
        v8 = 1'b0;
        v7 = 1'b0;
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            lows += int'(!tx8) + int'(!tx7);
        end
        chk("no_start_after_rst", lows, 0);

        // Single 8N1 frame 0xA5.
        go8(8'hA5);
        capture(180, 0, -1, -1, 8'h00);
        chk("a5_start_lat", int'(ct8[0]), 0);
        chk("a5_start_end", int'(ct8[15]), 0);
        chk("a5_bit0", int'(ct8[16]), 1);
        chk("a5_word", rx8(0, 8), 'hA5);
        chk("a5_busy_cnt", count8b(0, 180), 160);
        chk("a5_rdy_last", int'(cr8[159]), 1);
        chk("a5_rdy_prev", int'(cr8[158]), 0);
        chk("a5_stop", int'(ct8[159]), 1);

        // Back-to-back 0x00 then 0xFF with valid held.
        go8(8'h00);
        #1 d8 = 8'hFF;
        capture(340, 160, -1, -1, 8'h00);
        chk("b2b_w0", rx8(0, 8), 'h00);
        chk("b2b_stop0", int'(ct8[159]), 1);
        chk("b2b_start1", int'(ct8[160]), 0);
        chk("b2b_w1", rx8(160, 8), 'hFF);
        chk("b2b_busy", count8b(0, 320), 320);
        chk("b2b_idle", int'(cb8[320]), 0);

        // Data stability: tx_data changes mid-frame.
        go8(8'h81);
        capture(170, 0, -1, 39, 8'h7E);
        chk("stab_word", rx8(0, 8), 'h81);

        // Reset mid-frame, then a clean frame.
        go8(8'h3C);
        capture(50, 0, -1, -1, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", int'(tx8), 1);
        chk("mid_rst_busy", int'(busy8), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tx", int'(tx8), 1);
        go8(8'h5A);
        capture(170, 0, -1, -1, 8'h00);
        chk("post_rst_word", rx8(0, 8), 'h5A);
        chk("post_rst_busy", count8b(0, 170), 160);

        // 7 data bits, 2 stop bits.
        @(negedge clk);
        d7 = 7'h55;
        v7 = 1'b1;
        @(posedge clk);
        capture(170, -1, 0, -1, 8'h00);
        seq = 0;
        for (int j = 0; j < 170; j++) seq += int'(cb7[j]);
        chk("d7_busy_cnt", seq, 160);
        chk("d7_start", int'(ct7[0]), 0);
        chk("d7_word", rx7(0, 7), 'h55);
        chk("d7_stop1", int'(ct7[16 * 8 + 8]), 1);
        chk("d7_stop2", int'(ct7[16 * 9 + 8]), 1);
        chk("d7_idle", int'(ct7[165]), 1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
